// File: rtl/tx_serial_pkg.sv
// tx_serial_pkg: FSM states and line levels shared by the serial transmitter
package tx_serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: word buffer feeding the transmitter, combinational head read
module tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/tx_serial_sender.sv
// tx_serial_sender: drains the word buffer onto a start/data/parity/stop serial line
module tx_serial_sender
  import tx_serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  tx_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] shift, rd_data;
  logic parity, rd_en, bit_end, line;
  tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .level(level)
  );
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_nx = state;
    rd_en = 1'b0;
    line = LINE_IDLE;
    unique case (state)
      IDLE: begin
        rd_en = !empty;
        state_nx = empty ? IDLE : START;
      end
      START: begin
        line = START_BIT;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        line = shift[0];
        if (bit_end && bit_idx == BW'(DATA_WIDTH - 1)) state_nx = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: begin
        line = parity;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        line = STOP_BIT;
        // the closing stop clock may pop the next word for a gapless follow-on frame
        if (bit_end) begin
          rd_en = !empty;
          state_nx = empty ? IDLE : START;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  // line, busy and tx_done are registered together so they stay aligned on the wire
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      parity <= 1'b0;
      tx <= LINE_IDLE;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_nx;
      tx <= line;
      busy <= state != IDLE;
      tx_done <= state == STOP && bit_end;
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      if (rd_en) begin
        shift <= rd_data;
        parity <= ^rd_data ^ 1'(PARITY_ODD);
        bit_idx <= '0;
      end else if (state == DATA && bit_end) begin
        shift <= shift >> 1;
        bit_idx <= bit_idx + BW'(1);
      end
    end
endmodule

// File: tb/tb_tx_serial_sender.sv
// tb_tx_serial_sender: three parity variants against a frame-level line model
module tb_tx_serial_sender;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [2:0] tx, busy, done, full, empty;
  logic [2:0] lvl [3];
  int ntot = 0, npass = 0;
  always #5 clk = ~clk;

  tx_serial_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[0]), .empty(empty[0]),
    .level(lvl[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));
  tx_serial_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[1]), .empty(empty[1]),
    .level(lvl[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));
  tx_serial_sender #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full[2]), .empty(empty[2]),
    .level(lvl[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int fl(input int i);
    return i == 2 ? 40 : 44;
  endfunction

  // frame bit b of word w: start, 8 data LSB-first, optional parity, stop
  function automatic logic fbit(input logic [7:0] w, input int b, input int i);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (i != 2 && b == 9) return (^w) ^ (i == 1);
    return 1'b1;
  endfunction

  logic [7:0] mq [3][4];
  int mn [3] = '{0, 0, 0};
  int pos [3] = '{-1, -1, -1};
  logic [7:0] cur [3];
  logic etx [3] = '{1'b1, 1'b1, 1'b1};
  logic ebusy [3] = '{1'b0, 1'b0, 1'b0};
  logic edone [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mn[i] = 0; pos[i] = -1; etx[i] = 1'b1; ebusy[i] = 1'b0; edone[i] = 1'b0;
      end else begin
        bit fullp, pop;
        fullp = mn[i] == 4;
        pop = mn[i] > 0 && (pos[i] < 0 || pos[i] == fl(i) - 1);
        etx[i] = pos[i] < 0 ? 1'b1 : fbit(cur[i], pos[i] / 4, i);
        ebusy[i] = pos[i] >= 0;
        edone[i] = pos[i] == fl(i) - 1;
        if (pop) begin
          cur[i] = mq[i][0];
          for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
          mn[i]--;
          pos[i] = 0;
        end else if (pos[i] == fl(i) - 1) pos[i] = -1;
        else if (pos[i] >= 0) pos[i]++;
        if (wr_en && !fullp) begin
          mq[i][mn[i]] = wr_data;
          mn[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx%0d", i), int'(tx[i]), int'(etx[i]));
      chk($sformatf("busy%0d", i), int'(busy[i]), int'(ebusy[i]));
      chk($sformatf("done%0d", i), int'(done[i]), int'(edone[i]));
      chk($sformatf("level%0d", i), int'(lvl[i]), mn[i]);
      chk($sformatf("full%0d", i), int'(full[i]), int'(mn[i] == 4));
      chk($sformatf("empty%0d", i), int'(empty[i]), int'(mn[i] == 0));
    end
  end

  logic t0 [46], t1 [46], t2 [46], dn0 [46], dn2 [46], bs0 [46], bs2 [46];
  logic [10:0] line_a5 = 11'b10101001010;

  task automatic capture(input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
    chk("cap_w0", int'(tx[0]), 1);
    @(negedge clk);
    chk("cap_w1", int'(tx[0]), 1);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      t0[k] = tx[0]; t1[k] = tx[1]; t2[k] = tx[2];
      dn0[k] = done[0]; dn2[k] = done[2]; bs0[k] = busy[0]; bs2[k] = busy[2];
    end
  endtask

  task automatic wait_idle(output int pulses);
    int stable;
    stable = 0;
    pulses = 0;
    for (int k = 0; k < 600 && stable < 3; k++) begin
      @(negedge clk);
      if (done[0]) pulses++;
      stable = (busy == 3'b000 && empty == 3'b111) ? stable + 1 : 0;
    end
    chk("idle_timeout", int'(stable >= 3), 1);
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk); wr_en = 1'b1; wr_data = d;
  endtask

  initial begin
    int p, found, bcnt;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 7); chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty), 7); chk("rst_lvl", int'(lvl[0]), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    capture(8'hA5);
    chk("a5_first_low", int'(t0[0]), 0);
    for (int b = 0; b < 11; b++) chk($sformatf("a5_bit%0d", b), int'(t0[4*b+1]), int'(line_a5[b]));
    chk("a5_done42", int'(dn0[42]), 0); chk("a5_done43", int'(dn0[43]), 1);
    chk("a5_busy43", int'(bs0[43]), 1); chk("a5_busy44", int'(bs0[44]), 0);
    chk("a5_odd_par", int'(t1[37]), 1);
    chk("a5_nopar_done39", int'(dn2[39]), 1); chk("a5_nopar_busy39", int'(bs2[39]), 1);
    chk("a5_nopar_busy40", int'(bs2[40]), 0);
    wait_idle(p);
    capture(8'h07);
    chk("07_even_par", int'(t0[37]), 1); chk("07_odd_par", int'(t1[37]), 0);
    chk("07_nopar_stop", int'(t2[37]), 1); chk("07_nopar_done39", int'(dn2[39]), 1);
    wait_idle(p);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    @(negedge clk); wr_en = 1'b0;
    chk("b2b_lvl", int'(lvl[0]), 3); chk("b2b_full", int'(full[0]), 0);
    wait_idle(p);
    chk("b2b_frames", p, 4);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'hFF);
    @(negedge clk); wr_en = 1'b0;
    chk("drop_lvl", int'(lvl[0]), 4); chk("drop_full", int'(full[0]), 1);
    wait_idle(p);
    chk("drop_frames", p, 5);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    @(negedge clk); wr_data = 8'h99;
    chk("popfull_lvl4", int'(lvl[0]), 4);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(negedge clk);
      if (done[0]) found = 1;
    end
    wr_en = 1'b0;
    chk("popfull_seen", found, 1); chk("popfull_lvl3", int'(lvl[0]), 3);
    wait_idle(p);
    chk("popfull_rest", p, 4);
    push(8'h5A); push(8'hC3); push(8'h3C);
    @(negedge clk); wr_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_pre", int'(busy[0]), 1); chk("abort_lvl_pre", int'(lvl[0]), 2);
    #1 rst_n = 1'b0;
    #1 chk("abort_tx", int'(tx), 7); chk("abort_busy", int'(busy), 0);
    chk("abort_lvl", int'(lvl[0]), 0); chk("abort_empty", int'(empty), 7);
    @(negedge clk); #1 rst_n = 1'b1;
    bcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy != 3'b000) bcnt++;
    end
    chk("abort_silent", bcnt, 0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      wr_en = $urandom_range(0, 99) < (k < 1500 ? 30 : 3);
      wr_data = 8'($urandom);
    end
    @(negedge clk); wr_en = 1'b0;
    wait_idle(p);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
